// File: rtl/gate_arbiter.sv
// Round-robin arbiter sharing one W-bit bitwise gate unit among NREQ requesters.
// Define GATE_ARB_STATS_EN to add per-requester saturating grant counters (gnt_cnt).
module gate_arbiter #(
  parameter int NREQ  = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [W*NREQ-1:0]     a_in,
  input  logic [W*NREQ-1:0]     b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [W-1:0]          y,
  output logic [2:0]            y_id,
  output logic                  y_valid,
  input  logic                  y_ready,
`ifdef GATE_ARB_STATS_EN
  output logic [CNT_W*NREQ-1:0] gnt_cnt,
`endif
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [2:0]      lat_op;
  logic [W-1:0]    lat_a;
  logic [W-1:0]    lat_b;

  int              win_i;
  logic            hit;
  logic [NREQ-1:0] win_oh;
  logic [2:0]      sel_op;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;
  logic [2:0]      ptr_nxt;

  function automatic logic [W-1:0] gate_f(
    input logic [2:0]   o,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    case (o)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a & b);
      3'd4:    r = ~(a | b);
      3'd5:    r = ~(a ^ b);
      3'd6:    r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Scan downward so the lowest offset from ptr wins.
  always_comb begin
    win_i = 0;
    hit   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int s;
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      if (req[s]) begin
        win_i = s;
        hit   = 1'b1;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = hit && (i == win_i);
    end
    sel_op  = op[3*win_i +: 3];
    sel_a   = a_in[W*win_i +: W];
    sel_b   = b_in[W*win_i +: W];
    ptr_nxt = (win_i == NREQ - 1) ? 3'd0 : 3'(win_i + 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      y       <= '0;
      y_id    <= '0;
      y_valid <= 1'b0;
      lat_op  <= '0;
      lat_a   <= '0;
      lat_b   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (hit) begin
            lat_op <= sel_op;
            lat_a  <= sel_a;
            lat_b  <= sel_b;
            gnt    <= win_oh;
            y_id   <= 3'(win_i);
            ptr    <= ptr_nxt;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt     <= '0;
          y       <= gate_f(lat_op, lat_a, lat_b);
          y_valid <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef GATE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [NREQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (state == IDLE) begin
      for (int i = 0; i < NREQ; i++) begin
        if (win_oh[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_cnt
    assign gnt_cnt[CNT_W*g +: CNT_W] = cnt_q[g];
  end
`endif

endmodule
